// File: rtl/id_queue_stage.sv
// id_queue_stage: instruction-decode stage for the MIPS pipeline.
// Fetched instructions are buffered in a small FIFO. The head entry is decoded
// combinationally and captured in a registered ID/EX output. The stage supports
// a load-use bubble and a mispredict flush.
module id_queue_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_inst,
    input  logic [31:0]      if_pc,
    input  logic             if_branch_taken,
    input  logic             flush,
    input  logic             hazard_stall,
    input  logic             ex_ready,
    output logic             id_valid,
    output logic [5:0]       id_opcode,
    output logic [5:0]       id_alu_op,
    output logic [4:0]       id_rs,
    output logic [4:0]       id_rt,
    output logic [4:0]       id_rf_dest,
    output logic [31:0]      id_imm,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_branch_pc,
    output logic [31:0]      id_next_pc,
    output logic             id_force_jump,
    output logic             id_is_jr,
    output logic             id_branch_taken,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // Sign-extend a 16-bit immediate.
    function automatic logic signed [31:0] sext16(input logic [15:0] imm);
        logic signed [15:0] imm_s;
        imm_s = imm;
        return imm_s;
    endfunction

    // Immediate extension: logical ops zero-extend, lui shifts up, rest sign-extend.
    function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
        case (op)
            6'h0C, 6'h0D, 6'h0E: ext_imm = {16'h0000, imm};
            6'h0F:               ext_imm = {imm, 16'h0000};
            default:             ext_imm = unsigned'(sext16(imm));
        endcase
    endfunction

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic             bt_mem   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic push;
    logic load_en;

    assign if_ready = (count != FULL);
    assign push     = if_valid && if_ready && !flush;
    assign load_en  = (!id_valid || ex_ready) && (count != '0) && !hazard_stall && !flush;

    // Head-of-queue fields (decode stage p0)
    logic [5:0]         op_p0;
    logic [5:0]         fn_p0;
    logic [4:0]         rs_p0;
    logic [4:0]         rt_p0;
    logic [4:0]         rd_p0;
    logic [15:0]        imm16_p0;
    logic [25:0]        tgt_p0;
    logic [31:0]        pc_p0;
    logic               bt_p0;
    logic [5:0]         alu_op_p0;
    logic [4:0]         dest_p0;
    logic [31:0]        imm_p0;
    logic signed [31:0] off_p0;
    logic [31:0]        branch_pc_p0;
    logic [31:0]        next_pc_p0;
    logic               is_jr_p0;
    logic               force_jump_p0;

    assign op_p0    = inst_mem[rd_ptr][31:26];
    assign rs_p0    = inst_mem[rd_ptr][25:21];
    assign rt_p0    = inst_mem[rd_ptr][20:16];
    assign rd_p0    = inst_mem[rd_ptr][15:11];
    assign fn_p0    = inst_mem[rd_ptr][5:0];
    assign imm16_p0 = inst_mem[rd_ptr][15:0];
    assign tgt_p0   = inst_mem[rd_ptr][25:0];
    assign pc_p0    = pc_mem[rd_ptr];
    assign bt_p0    = bt_mem[rd_ptr];

    // Store accepted fetch entries; storage needs no reset since pointers gate it.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= if_inst;
            pc_mem[wr_ptr]   <= if_pc;
            bt_mem[wr_ptr]   <= if_branch_taken;
        end
    end

    // Queue pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (load_en)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, load_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Combinational decode of the queue head.
    always_comb begin
        alu_op_p0     = (op_p0 == 6'h00) ? fn_p0 : op_p0;
        dest_p0       = rt_p0;
        if (op_p0 == 6'h00)
            dest_p0 = rd_p0;
        else if (op_p0 == 6'h03)
            dest_p0 = 5'd31;
        imm_p0        = ext_imm(op_p0, imm16_p0);
        off_p0        = sext16(imm16_p0) <<< 2;
        branch_pc_p0  = pc_p0 + 32'd4 + unsigned'(off_p0);
        next_pc_p0    = pc_p0 + 32'd4;
        if (op_p0 == 6'h02 || op_p0 == 6'h03)
            next_pc_p0 = {pc_p0[31:28], tgt_p0, 2'b00};
        is_jr_p0      = (op_p0 == 6'h00) && (fn_p0 == 6'h08);
        force_jump_p0 = is_jr_p0 || (op_p0 == 6'h02) || (op_p0 == 6'h03);
    end

    // ID/EX register (stage p1): load on issue, bubble when EX is free but nothing issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid        <= 1'b0;
            id_opcode       <= '0;
            id_alu_op       <= '0;
            id_rs           <= '0;
            id_rt           <= '0;
            id_rf_dest      <= '0;
            id_imm          <= '0;
            id_pc           <= '0;
            id_branch_pc    <= '0;
            id_next_pc      <= '0;
            id_force_jump   <= 1'b0;
            id_is_jr        <= 1'b0;
            id_branch_taken <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (load_en) begin
            id_valid        <= 1'b1;
            id_opcode       <= op_p0;
            id_alu_op       <= alu_op_p0;
            id_rs           <= rs_p0;
            id_rt           <= rt_p0;
            id_rf_dest      <= dest_p0;
            id_imm          <= imm_p0;
            id_pc           <= pc_p0;
            id_branch_pc    <= branch_pc_p0;
            id_next_pc      <= next_pc_p0;
            id_force_jump   <= force_jump_p0;
            id_is_jr        <= is_jr_p0;
            id_branch_taken <= bt_p0;
        end else if (!id_valid || ex_ready) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: doc/id_queue_stage.md
Name: id_queue_stage

Overview:
- Registered instruction-decode stage for the MIPS pipeline, sitting between instruction fetch and execute.
- Accepts fetched instructions through a valid/ready handshake into a parametrised FIFO of DEPTH entries.
- Decodes the FIFO head into a registered ID/EX output with a valid/ready handshake toward EX.
- Adds a load-use stall bubble and a branch-mispredict flush. Operand read and forwarding stay outside this block; it exports register indices only.

Parameters:
- DEPTH, 4, FIFO entries. Power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch offers an instruction.
- if_ready  out  1  FIFO can accept: count != DEPTH.
- if_inst  in  32  instruction word.
- if_pc  in  32  instruction address.
- if_branch_taken  in  1  fetch predicted taken.
- flush  in  1  mispredict flush. Synchronous, highest priority.
- hazard_stall  in  1  forward unit reports a load-use hazard on the FIFO head.
- ex_ready  in  1  EX accepts the ID/EX register this cycle.
- id_valid  out  1  ID/EX register holds an instruction.
- id_opcode  out  6  inst[31:26].
- id_alu_op  out  6  funct if opcode==0, else opcode.
- id_rs / id_rt  out  5 each  source register indices.
- id_rf_dest  out  5  rd for R-type; 31 for jal (opcode 3); otherwise rt.
- id_imm  out  32  extended imm16.
- id_pc  out  32  pc of the instruction.
- id_branch_pc  out  32  pc+4+(sext(imm)<<2).
- id_next_pc  out  32  jump target for opcode 2/3, else pc+4.
- id_force_jump  out  1  opcode 2, opcode 3, or (opcode 0 and funct 8).
- id_is_jr  out  1  opcode 0 and funct 8. EX redirects to rs.
- id_branch_taken  out  1  registered copy of if_branch_taken.
- count  out  CNT_W  FIFO occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous): rd_ptr=wr_ptr=count=0; id_valid=0; all id_* data outputs 0; if_ready=1.
- Push: if_valid && if_ready && !flush. The entry {inst, pc, branch_taken} is written at wr_ptr. Pointers wrap modulo DEPTH.
- No bypass: a full FIFO gives if_ready=0 even if a pop occurs the same cycle.
- An empty FIFO cannot pop in the cycle it is pushed.
- load_en = (!id_valid || ex_ready) && count!=0 && !hazard_stall && !flush.
  - On load_en, the head is popped, decoded combinationally, and registered into id_*; id_valid<=1.
- If (!id_valid || ex_ready) && !load_en && !flush: id_valid<=0 (bubble). id_* data holds its last value.
- If id_valid && !ex_ready: the ID/EX register holds unchanged, and hazard_stall is ignored.
- Push and pop in the same cycle leave count unchanged.
- Minimum latency: pushed at edge k, visible on id_* after edge k+1.
- Flush: at the edge, count=0, pointers=0, id_valid=0, and any same-cycle push is dropped. Reset beats flush.
- Immediate extension:
  - Zero-extend for opcodes 0x0C (andi), 0x0D (ori), 0x0E (xori).
  - lui (0x0F) gives id_imm = {imm,16'b0}.
  - Sign-extend all others.
- Jump target = {pc[31:28], inst[25:0], 2'b00}.
- All pc adds are 32-bit modulo. Overflow wraps silently.
- Reset mid-operation discards every queued instruction; no partial state survives.

Test Plan:
- Push 0x2008FFFF (addi) at pc 0x00400000, ex_ready=1 -> one cycle later: id_valid=1, id_imm=0xFFFFFFFF, id_rf_dest=8, id_alu_op=0x08, id_next_pc=0x00400004.
- Push 0x3508FFFF (ori), then 0x3C081234 (lui) -> id_imm=0x0000FFFF, then 0x12340000.
- Push 0x0C100004 (jal) at pc 0x00400010 -> id_next_pc=0x00400010, id_rf_dest=31, id_force_jump=1. Push 0x1109FFFE (beq) at pc 0x00400020 -> id_branch_pc=0x0040001C. Push 0x01000008 (jr) -> id_is_jr=1, id_force_jump=1.
- DEPTH=4, ex_ready=0, stream 6 instructions -> 5 accepted (4 in FIFO, 1 in ID/EX), then if_ready=0 and count=4. Raise ex_ready -> in-order drain, no loss or duplication.
- hazard_stall=1 for 2 cycles with the FIFO non-empty and ex_ready=1 -> id_valid=0 for 2 cycles, head retained, issued next cycle.
- flush with count=3 and a same-cycle push -> next cycle: count=0, id_valid=0, pushed instruction absent. Then drop rst_n mid-stream -> immediate reset values, if_ready=1.
